ram_write_port: RTL and testbench



---
 rtl/cpu_pkg.sv | 49 ++++
 rtl/mmu_walker.sv | 106 ++++++++++
 rtl/ram_write_port.sv | 140 ++++++++++++++
 tb/tb_ram_write_port.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared constants and types for the CPU memory path: MMU geometry, decoder
// opcodes, address/segment types and the write-port state encodings.
// No ports (package).
// ----------------------------------------------------------------------------
package cpu_pkg;

    // MMU / memory geometry
    localparam int unsigned PAGE_SIZE = 151;    // bytes per page/segment
    localparam int unsigned RAM_SIZE  = 65534;  // highest valid physical byte address
    localparam int unsigned MAX_WALK  = 455;    // chain steps before giving up
    localparam int unsigned STEP_W    = $clog2(MAX_WALK + 1);

    // Decoder opcodes
    localparam logic [3:0] OPCODE_NOP     = 4'h0;
    localparam logic [3:0] OPCODE_LOADI   = 4'h1;
    localparam logic [3:0] OPCODE_RAM2REG = 4'h2;
    localparam logic [3:0] OPCODE_REG2RAM = 4'h3;

    typedef logic [11:0] seg_t;    // physical segment / chain table index
    typedef logic [15:0] laddr_t;  // logical byte address
    typedef logic [15:0] paddr_t;  // physical byte address
    typedef logic [7:0]  off_t;    // byte offset within a page

    // Write-port sequencer states
    typedef enum logic [2:0] {
        WP_IDLE  = 3'd0,
        WP_XLATE = 3'd1,
        WP_WALK  = 3'd2,
        WP_WRITE = 3'd3,
        WP_DONE  = 3'd4,
        WP_FAULT = 3'd5
    } wp_state_t;

    // MMU chain walker states
    typedef enum logic [1:0] {
        WK_IDLE = 2'd0,
        WK_HEAD = 2'd1,
        WK_CMP  = 2'd2
    } wk_state_t;

    // Physical address in 24 bits so an out-of-range segment cannot wrap
    // back into valid RAM before the range check.
    function automatic logic [23:0] phys_of(input seg_t seg, input off_t off);
        return 24'(seg) * 24'(PAGE_SIZE) + 24'(off);
    endfunction

endpackage

// File: rtl/mmu_walker.sv
// ----------------------------------------------------------------------------
// mmu_walker
// Translates a logical page to a physical segment by following the MMU page
// chain, starting at the process's segment for logical page 0.
//   clk, rst       clock, asynchronous active-high reset
//   start          one-cycle request (walker must be idle)
//   lpage          logical page to find
//   start_segment  segment of logical page 0 (head of the chain)
//   tbl_addr       chain table index presented to the table
//   tbl_next       chain entry at tbl_addr, valid one cycle later
//   tbl_lpage      logical page at tbl_addr, valid one cycle later
//   seg            translated segment, valid while hit is high
//   hit            one-cycle pulse: translation found
//   miss           one-cycle pulse: chain end or step limit reached
// ----------------------------------------------------------------------------
module mmu_walker
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] lpage,
    input  logic [11:0] start_segment,
    output logic [11:0] tbl_addr,
    input  logic [11:0] tbl_next,
    input  logic [11:0] tbl_lpage,
    output logic [11:0] seg,
    output logic        hit,
    output logic        miss
);

    wk_state_t          r_state;
    logic               r_phase;     // 0: table read in flight, 1: data valid
    seg_t               r_lpage;
    seg_t               r_cur_seg;
    seg_t               r_tbl_addr;
    logic [STEP_W-1:0]  r_steps;

    logic w_zero_page;
    logic w_eval;
    logic w_match;
    logic w_chain_end;
    logic w_limit;

    // Page 0 never touches the table: it is the start segment by definition.
    assign w_zero_page = (lpage == '0);
    assign w_eval      = (r_state == WK_CMP) && r_phase;
    assign w_match     = (tbl_lpage == r_lpage);
    // A segment pointing at itself terminates the chain.
    assign w_chain_end = (tbl_next == r_cur_seg);
    assign w_limit     = (r_steps == STEP_W'(MAX_WALK));

    assign hit  = ((r_state == WK_IDLE) && start && w_zero_page) || (w_eval && w_match);
    assign miss = w_eval && !w_match && (w_chain_end || w_limit);
    assign seg  = ((r_state == WK_IDLE) && w_zero_page) ? start_segment : r_cur_seg;

    assign tbl_addr = r_tbl_addr;

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= WK_IDLE;
            r_phase    <= 1'b0;
            r_lpage    <= '0;
            r_cur_seg  <= '0;
            r_tbl_addr <= '0;
            r_steps    <= '0;
        end else begin
            case (r_state)
                WK_IDLE: begin
                    if (start && !w_zero_page) begin
                        r_state    <= WK_HEAD;
                        r_phase    <= 1'b0;
                        r_lpage    <= lpage;
                        r_tbl_addr <= start_segment;
                        r_steps    <= '0;
                    end
                end
                WK_HEAD: begin
                    // Skip the head entry itself: it holds page 0.
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        r_cur_seg  <= tbl_next;
                        r_tbl_addr <= tbl_next;
                        r_state    <= WK_CMP;
                    end
                end
                WK_CMP: begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        if (hit || miss) begin
                            r_state <= WK_IDLE;
                        end else begin
                            r_cur_seg  <= tbl_next;
                            r_tbl_addr <= tbl_next;
                            r_steps    <= r_steps + STEP_W'(1);
                        end
                    end
                end
                default: r_state <= WK_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ram_write_port.sv
// ----------------------------------------------------------------------------
// ram_write_port
// Store path for REG2RAM: splits a 16-bit write into two big-endian byte
// writes (high byte at addr, low byte at addr+1), translates each byte
// address through the MMU chain and drives BRAM port A.
//   clk, rst        clock, asynchronous active-high reset
//   req_valid/ready request handshake (ready only when idle)
//   req_addr        logical address of the high byte
//   req_data        [15:8] -> req_addr, [7:0] -> req_addr+1
//   start_segment   segment of logical page 0, sampled at accept
//   tbl_addr/next/lpage  MMU chain table port (1-cycle read latency)
//   ram_en/we/addr/din   BRAM port A
//   done            one-cycle pulse: both bytes written
//   fault           one-cycle pulse: translation failed, request aborted
// ----------------------------------------------------------------------------
module ram_write_port
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_data,
    input  logic [11:0] start_segment,
    output logic [11:0] tbl_addr,
    input  logic [11:0] tbl_next,
    input  logic [11:0] tbl_lpage,
    output logic        ram_en,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        done,
    output logic        fault
);

    wp_state_t r_state;
    logic      r_byte_lo;     // 0: high byte in flight, 1: low byte
    laddr_t    r_cur_addr;
    laddr_t    r_req_addr;
    logic [15:0] r_req_data;
    seg_t      r_start_seg;
    seg_t      r_seg;

    wp_state_t   w_state_nx;
    logic        w_start;
    seg_t        w_lpage;
    off_t        w_off;
    logic [11:0] w_seg;
    logic        w_hit;
    logic        w_miss;
    logic [23:0] w_phys;
    logic        w_phys_bad;
    logic        w_wr;

    assign w_lpage = seg_t'(r_cur_addr / laddr_t'(PAGE_SIZE));
    assign w_off   = off_t'(r_cur_addr % laddr_t'(PAGE_SIZE));
    assign w_start = (r_state == WP_XLATE);

    mmu_walker u_walker (
        .clk           (clk),
        .rst           (rst),
        .start         (w_start),
        .lpage         (w_lpage),
        .start_segment (r_start_seg),
        .tbl_addr      (tbl_addr),
        .tbl_next      (tbl_next),
        .tbl_lpage     (tbl_lpage),
        .seg           (w_seg),
        .hit           (w_hit),
        .miss          (w_miss)
    );

    assign w_phys     = phys_of(r_seg, w_off);
    assign w_phys_bad = (w_phys > 24'(RAM_SIZE));
    // Port A strobes are decoded from the state register so a reset removes
    // them without waiting for a clock edge.
    assign w_wr       = (r_state == WP_WRITE) && !w_phys_bad;

    assign req_ready = (r_state == WP_IDLE);
    assign ram_en    = w_wr;
    assign ram_we    = w_wr;
    assign ram_addr  = w_wr ? paddr_t'(w_phys) : '0;
    assign ram_din   = !w_wr    ? 8'h00 :
                       r_byte_lo ? r_req_data[7:0] : r_req_data[15:8];
    assign done      = (r_state == WP_DONE);
    assign fault     = (r_state == WP_FAULT);

    // NOTE: next-state is defaulted to the current state before the case so
    // no path through this block can infer a latch.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            WP_IDLE:  if (req_valid) w_state_nx = WP_XLATE;
            WP_XLATE: w_state_nx = w_hit ? WP_WRITE : WP_WALK;
            WP_WALK: begin
                if (w_hit)       w_state_nx = WP_WRITE;
                else if (w_miss) w_state_nx = WP_FAULT;
            end
            WP_WRITE: begin
                if (w_phys_bad)     w_state_nx = WP_FAULT;
                else if (r_byte_lo) w_state_nx = WP_DONE;
                else                w_state_nx = WP_XLATE;
            end
            WP_DONE:  w_state_nx = WP_IDLE;
            WP_FAULT: w_state_nx = WP_IDLE;
            default:  w_state_nx = WP_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= WP_IDLE;
            r_byte_lo   <= 1'b0;
            r_cur_addr  <= '0;
            r_req_addr  <= '0;
            r_req_data  <= '0;
            r_start_seg <= '0;
            r_seg       <= '0;
        end else begin
            r_state <= w_state_nx;
            if ((r_state == WP_IDLE) && req_valid) begin
                r_req_addr  <= req_addr;
                r_req_data  <= req_data;
                r_start_seg <= start_segment;
                r_cur_addr  <= req_addr;
                r_byte_lo   <= 1'b0;
            end
            if (((r_state == WP_XLATE) || (r_state == WP_WALK)) && w_hit) begin
                r_seg <= w_seg;
            end
            // After the high byte lands, retarget at addr+1 (wraps at 16 bits).
            if (w_wr && !r_byte_lo) begin
                r_byte_lo  <= 1'b1;
                r_cur_addr <= r_req_addr + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ram_write_port.sv
// ----------------------------------------------------------------------------
// tb_ram_write_port
// Scoreboard bench: the driver computes each request's expected byte writes
// and completion/fault from a page-chain model and queues them; a monitor
// pops and compares whenever the DUT strobes port A, done or fault.
// ----------------------------------------------------------------------------
module tb_ram_write_port;
    import cpu_pkg::*;

    localparam int K_WR    = 0;
    localparam int K_DONE  = 1;
    localparam int K_FAULT = 2;

    typedef struct {
        int kind;
        int addr;
        int data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_addr = '0;
    logic [15:0] req_data = '0;
    logic [11:0] start_segment = '0;
    logic [11:0] tbl_addr;
    logic [11:0] tbl_next;
    logic [11:0] tbl_lpage;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        done;
    logic        fault;

    logic [11:0] chain [4096];
    logic [11:0] lp    [4096];

    ev_t exp_q[$];
    ev_t mon_e;
    int  mon_kind;
    int  n_vec = 0;
    int  n_fail = 0;
    int  done_cnt = 0;

    ram_write_port dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .start_segment (start_segment),
        .tbl_addr      (tbl_addr),
        .tbl_next      (tbl_next),
        .tbl_lpage     (tbl_lpage),
        .ram_en        (ram_en),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_din       (ram_din),
        .done          (done),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    // Chain table with one cycle of read latency.
    always @(posedge clk) begin
        tbl_next  <= chain[tbl_addr];
        tbl_lpage <= lp[tbl_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference translation: logical byte address -> physical, or fault.
    function automatic void xlate(input int addr, input int s, output bit ok, output int phys);
        int lpage;
        int off;
        int cur;
        int steps;
        lpage = addr / 151;
        off   = addr % 151;
        ok    = 1'b0;
        phys  = 0;
        if (lpage == 0) begin
            cur = s;
        end else begin
            cur   = int'(chain[s]);
            steps = 0;
            while (int'(lp[cur]) != lpage) begin
                if (int'(chain[cur]) == cur || steps == 455) return;
                cur = int'(chain[cur]);
                steps++;
            end
        end
        phys = cur * 151 + off;
        if (phys > 65534) return;
        ok = 1'b1;
    endfunction

    task automatic push_req(input logic [15:0] a, input logic [15:0] d, input logic [11:0] s);
        ev_t         e;
        bit          ok;
        int          phys;
        logic [15:0] ad;
        for (int b = 0; b < 2; b++) begin
            ad = (b == 0) ? a : a + 16'd1;
            xlate(int'(ad), int'(s), ok, phys);
            if (!ok) begin
                e.kind = K_FAULT; e.addr = 0; e.data = 0;
                exp_q.push_back(e);
                return;
            end
            e.kind = K_WR;
            e.addr = phys;
            e.data = (b == 0) ? int'(d[15:8]) : int'(d[7:0]);
            exp_q.push_back(e);
        end
        e.kind = K_DONE; e.addr = 0; e.data = 0;
        exp_q.push_back(e);
    endtask

    // Call at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] d,
                         input logic [11:0] s, input bit keep);
        int n = 0;
        req_addr = a; req_data = d; start_segment = s; req_valid = 1'b1;
        #1;
        while (!req_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_for_accept", req_ready, 1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        push_req(a, d, s);
        @(posedge clk);
        @(negedge clk);
        start_segment = 12'($urandom);  // must not be resampled
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (!(req_ready && exp_q.size() == 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_completes"}, {31'd0, req_ready && (exp_q.size() == 0)}, 1);
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst && (ram_en || ram_we || done || fault)) begin
            mon_kind = ram_we ? K_WR : (done ? K_DONE : K_FAULT);
            if (done) done_cnt++;
            check("ram_en_equals_ram_we", ram_en, ram_we);
            check("done_fault_exclusive", done & fault, 0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_output: kind %0d addr 0x%0h din 0x%0h, queue empty",
                         mon_kind, ram_addr, ram_din);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind", mon_kind, mon_e.kind);
                if (mon_kind == K_WR && mon_e.kind == K_WR) begin
                    check("ram_addr", ram_addr, mon_e.addr);
                    check("ram_din", ram_din, mon_e.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d events pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        for (int i = 0; i < 4096; i++) begin
            chain[i] = 12'(i);
            lp[i]    = 12'hFFF;
        end
        chain[0] = 12'd5; chain[5] = 12'd2; chain[2] = 12'd1; chain[1] = 12'd1;
        lp[5] = 12'd3; lp[2] = 12'd2; lp[1] = 12'd1;
        chain[100] = 12'd434; chain[434] = 12'd434; lp[434] = 12'd7;
        chain[200] = 12'd201; chain[201] = 12'd200;
        chain[300] = 12'd301; chain[301] = 12'd301; lp[301] = 12'd434;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_req_ready", req_ready, 1);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);
        check("rst_tbl_addr", tbl_addr, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_din", ram_din, 0);

        // Page-0 word: latency and no table traffic.
        issue(16'h0010, 16'hABCD, 12'd0, 1'b0);
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("page0_done_cycle", n, 5);
        @(negedge clk);
        check("page0_ready_after_done", req_ready, 1);
        check("page0_tbl_untouched", tbl_addr, 0);
        wait_idle("page0");

        issue(16'd150, 16'h1234, 12'd0, 1'b0);   wait_idle("straddle_walk");
        issue(16'd453, 16'hBEEF, 12'd0, 1'b0);   wait_idle("first_compare");
        issue(16'd604, 16'h5555, 12'd0, 1'b0);   wait_idle("chain_end_fault");
        issue(16'd1057, 16'hA55A, 12'd100, 1'b0); wait_idle("ram_top_then_fault");
        issue(16'd1, 16'h0102, 12'd434, 1'b0);   wait_idle("ram_overflow");
        issue(16'hFFFF, 16'h7788, 12'd300, 1'b0); wait_idle("addr_wrap");
        issue(16'd755, 16'h4242, 12'd200, 1'b0); wait_idle("max_walk");

        // Reset in the low byte's walk: high byte stays written, rest aborted.
        issue(16'd453, 16'hBEEF, 12'd0, 1'b0);
        n = 0;
        while (!ram_we && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("walk_rst_high_written", ram_we, 1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("walk_rst_ram_we", ram_we, 0);
        check("walk_rst_req_ready", req_ready, 1);
        check("walk_rst_tbl_addr", tbl_addr, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(16'h0010, 16'hABCD, 12'd0, 1'b0);  wait_idle("after_reset");

        // Reset while port A is writing: strobe must fall without a clock.
        issue(16'h0040, 16'h9966, 12'd0, 1'b0);
        n = 0;
        while (!ram_we && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("write_rst_saw_write", ram_we, 1);
        #2 rst = 1'b1;
        #1;
        check("write_rst_ram_we_async", ram_we, 0);
        check("write_rst_ram_en_async", ram_en, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back with req_valid held high.
        d0 = done_cnt;
        issue(16'h0020, 16'h1122, 12'd0, 1'b1);
        issue(16'd453, 16'h3344, 12'd0, 1'b0);
        wait_idle("back_to_back");
        check("b2b_done_pulses", done_cnt - d0, 2);

        // Randomized requests.
        for (int k = 0; k < 40; k++) begin
            logic [11:0] s;
            logic [15:0] a;
            case ($urandom_range(0, 3))
                0:       s = 12'd0;
                1:       s = 12'd5;
                2:       s = 12'd100;
                default: s = 12'd300;
            endcase
            a = $urandom_range(0, 1) ? 16'($urandom_range(0, 760)) : 16'($urandom);
            issue(a, 16'($urandom), s, 1'b0);
            wait_idle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
